// File: rtl/lms_weight_bank_pkg.sv
// lms_pkg: shared state encoding and sizing/saturation helpers for the LMS weight bank
package lms_pkg;
   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} lms_state_t;
   function automatic int idx_w(input int taps);
      return taps > 1 ? $clog2(taps) : 1;
   endfunction
   // Largest positive value of a ww-bit signed weight; the negative bound is its complement.
   function automatic logic [63:0] sat_clamp(input int ww);
      return (64'd1 << (ww - 1)) - 64'd1;
   endfunction
endpackage

// File: rtl/lms_weight_bank_if.sv
// lms_weight_bank_if: control, sample and weight bus of the LMS weight bank
//   start/clear/e/mu_shift/ref_flat : requester -> bank
//   busy/done/sat/weight_flat       : bank -> requester
interface lms_weight_bank_if #(
   parameter int TAPS = 32,
   parameter int DW   = 14,
   parameter int WW   = 32
);
   localparam int MW = $clog2(2 * DW);
   logic                 start;
   logic                 clear;
   logic signed [DW-1:0] e;
   logic [MW-1:0]        mu_shift;
   logic [TAPS*DW-1:0]   ref_flat;
   logic                 busy;
   logic                 done;
   logic                 sat;
   logic [TAPS*WW-1:0]   weight_flat;
   modport master (output start, clear, e, mu_shift, ref_flat, input busy, done, sat, weight_flat);
   modport slave  (input start, clear, e, mu_shift, ref_flat, output busy, done, sat, weight_flat);
endinterface

// File: rtl/lms_weight_bank_tap_mac.sv
// lms_tap_mac: one-tap LMS update y = sat(w + ((e * r) >>> mu_shift)) with saturation flag
//   e, r     : signed samples
//   mu_shift : step-size exponent
//   w        : current weight
//   y, sat   : clamped new weight, high when clamping occurred
module lms_tap_mac import lms_pkg::*; #(
   parameter int DW = 14,
   parameter int WW = 32,
   parameter int MW = 5
) (
   input  logic signed [DW-1:0] e,
   input  logic signed [DW-1:0] r,
   input  logic [MW-1:0]        mu_shift,
   input  logic signed [WW-1:0] w,
   output logic signed [WW-1:0] y,
   output logic                 sat
);
   localparam logic [WW-1:0] HI = WW'(sat_clamp(WW));
   logic signed [2*DW-1:0] p;
   logic signed [2*DW-1:0] p_sh;
   logic signed [WW:0]     s;
   always_comb begin
      p    = e * r;
      p_sh = p >>> mu_shift;
      s    = {w[WW-1], w} + {{(WW + 1 - 2 * DW){p_sh[2*DW-1]}}, p_sh};
      // The WW+1-bit sum is out of range exactly when its two top bits differ.
      sat  = s[WW] ^ s[WW-1];
      y    = sat ? (s[WW] ? ~HI : HI) : s[WW-1:0];
   end
endmodule

// File: rtl/lms_weight_bank.sv
// lms_weight_bank: LMS coefficient store; each start sweeps all taps once through a one-stage update pipe
//   clk, rstn : clock, synchronous active-low reset
//   bus       : slave side of lms_weight_bank_if (start/clear/e/mu_shift/ref_flat in,
//               busy/done/sat/weight_flat out)
module lms_weight_bank import lms_pkg::*; #(
   parameter int TAPS = 32,
   parameter int DW   = 14,
   parameter int WW   = 32
) (
   input logic              clk,
   input logic              rstn,
   lms_weight_bank_if.slave bus
);
   localparam int IDX_W = idx_w(TAPS);
   localparam int MW    = $clog2(2 * DW);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(TAPS - 1);

   if (WW < 2 * DW) begin : g_ww_chk
      $error("lms_weight_bank: WW must be at least 2*DW");
   end
   if (WW > 64 || TAPS < 2) begin : g_range_chk
      $error("lms_weight_bank: need TAPS >= 2 and WW <= 64");
   end

   lms_state_t           state;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     upd_idx;
   logic                 upd_vld;
   logic signed [WW-1:0] upd_val;
   logic signed [DW-1:0] e_q;
   logic [MW-1:0]        mu_q;
   logic [TAPS*WW-1:0]   w;
   logic signed [WW-1:0] mac_y;
   logic                 mac_sat;
   logic                 busy;
   logic                 done;
   logic                 sat;

   lms_tap_mac #(.DW(DW), .WW(WW), .MW(MW)) u_mac (
      .e        (e_q),
      .r        (bus.ref_flat[idx*DW +: DW]),
      .mu_shift (mu_q),
      .w        (w[idx*WW +: WW]),
      .y        (mac_y),
      .sat      (mac_sat)
   );

   // Clear shares the reset path, so a start in the same cycle is dropped and no done is emitted.
   always_ff @(posedge clk)
      if (!rstn || bus.clear) begin
         state   <= IDLE;
         idx     <= '0;
         upd_idx <= '0;
         upd_vld <= 1'b0;
         upd_val <= '0;
         e_q     <= '0;
         mu_q    <= '0;
         w       <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sat     <= 1'b0;
      end else begin
         done    <= 1'b0;
         upd_vld <= 1'b0;
         if (upd_vld) w[upd_idx*WW +: WW] <= upd_val;
         case (state)
            IDLE:
               if (bus.start) begin
                  e_q   <= bus.e;
                  mu_q  <= bus.mu_shift;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= SWEEP;
               end
            SWEEP: begin
               upd_vld <= 1'b1;
               upd_idx <= idx;
               upd_val <= mac_y;
               if (mac_sat) sat <= 1'b1;
               idx     <= idx == LAST ? '0 : idx + 1'b1;
               if (idx == LAST) state <= DRAIN;
            end
            DRAIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.sat         = sat;
   assign bus.weight_flat = w;
endmodule

// File: tb/tb_lms_weight_bank.sv
// tb_lms_weight_bank: table-driven sweeps plus hand sequences for reset, saturation, clear and busy handling
module tb_lms_weight_bank;
   localparam int TAPS = 32;
   localparam int DW   = 14;
   localparam int WW   = 32;
   localparam int WS   = 28;
   localparam int MW   = $clog2(2 * DW);

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   lms_weight_bank_if #(.TAPS(TAPS), .DW(DW), .WW(WW)) b ();
   lms_weight_bank_if #(.TAPS(TAPS), .DW(DW), .WW(WS)) bs ();

   lms_weight_bank #(.TAPS(TAPS), .DW(DW), .WW(WW)) dut   (.clk(clk), .rstn(rstn), .bus(b));
   lms_weight_bank #(.TAPS(TAPS), .DW(DW), .WW(WS)) dut_s (.clk(clk), .rstn(rstn), .bus(bs));

   typedef struct {
      bit                   clr;
      logic signed [DW-1:0] e;
      int                   mu;
      int                   ra;
      int                   rb;
      longint               xa;
      longint               xb;
   } vec_t;

   int total = 0;
   int bad   = 0;
   logic [TAPS*WW-1:0] snap  [0:TAPS+4];
   logic               bsnap [0:TAPS+4];
   int dcyc;
   int ndone;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic signed [63:0] wof(input logic [TAPS*WW-1:0] v, input int k);
      return $signed(v[k*WW +: WW]);
   endfunction

   function automatic logic signed [63:0] wsat(input int k);
      return $signed(bs.weight_flat[k*WS +: WS]);
   endfunction

   task automatic set_ref(input int ra, input int rb);
      for (int k = 0; k < TAPS; k++) b.ref_flat[k*DW +: DW] = DW'(ra + rb * k);
   endtask

   task automatic pulse_clear();
      b.clear = 1'b1;
      @(negedge clk);
      b.clear = 1'b0;
   endtask

   // Called just after a negedge; snap[c] holds the state seen after edge E(c).
   task automatic do_sweep(input logic signed [DW-1:0] ev, input int mu);
      b.start    = 1'b1;
      b.e        = ev;
      b.mu_shift = MW'(mu);
      @(negedge clk);
      b.start  = 1'b0;
      dcyc     = -1;
      ndone    = 0;
      snap[0]  = b.weight_flat;
      bsnap[0] = b.busy;
      for (int c = 1; c <= TAPS + 4; c++) begin
         @(negedge clk);
         snap[c]  = b.weight_flat;
         bsnap[c] = b.busy;
         if (b.done === 1'b1) begin
            ndone++;
            if (dcyc < 0) dcyc = c;
         end
      end
   endtask

   initial begin
      vec_t v [7];
      int n, d1, d2, bseen;
      v[0] = '{1'b1, 14'sd3,     0,  1,    1,  3,        3};
      v[1] = '{1'b0, 14'sd3,     0,  1,    1,  6,        6};
      v[2] = '{1'b1, -14'sd2,    2,  100,  0,  -50,      0};
      v[3] = '{1'b0, -14'sd2,    2,  100,  0,  -100,     0};
      v[4] = '{1'b1, 14'sd5,     1,  -3,   -2, -8,       -5};
      v[5] = '{1'b1, -14'sd8192, 27, 8191, 0,  -1,       0};
      v[6] = '{1'b1, -14'sd8192, 0,  -8192, 0, 67108864, 0};

      b.start = 1'b1; b.clear = 1'b0; b.e = 14'sd5; b.mu_shift = '0;
      set_ref(1, 1);
      bs.start = 1'b1; bs.clear = 1'b0; bs.e = -14'sd8192; bs.mu_shift = '0;
      for (int k = 0; k < TAPS; k++) bs.ref_flat[k*DW +: DW] = -14'sd8192;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_weights_zero", b.weight_flat === '0, 1);
      chk("rst_busy", b.busy, 0);
      chk("rst_done", b.done, 0);
      chk("rst_sat", b.sat, 0);
      chk("rst_s_busy", bs.busy, 0);
      rstn = 1'b1; b.start = 1'b0; bs.start = 1'b0;
      @(negedge clk);
      chk("rst_start_ignored", b.busy, 0);

      for (int s = 1; s <= 3; s++) begin
         bs.start = 1'b1;
         @(negedge clk);
         bs.start = 1'b0;
         n = 0;
         for (int c = 0; c < TAPS + 4; c++) begin
            @(negedge clk);
            if (bs.done === 1'b1) n++;
         end
         chk($sformatf("sat_s%0d_done", s), n, 1);
         chk($sformatf("sat_s%0d_w0", s), wsat(0), s == 1 ? 64'sd67108864 : 64'sd134217727);
         chk($sformatf("sat_s%0d_w31", s), wsat(TAPS - 1), s == 1 ? 64'sd67108864 : 64'sd134217727);
         chk($sformatf("sat_s%0d_flag", s), bs.sat, s == 1 ? 0 : 1);
      end
      bs.clear = 1'b1;
      @(negedge clk);
      bs.clear = 1'b0;
      chk("sat_clear_flag", bs.sat, 0);
      chk("sat_clear_w", bs.weight_flat === '0, 1);

      for (int i = 0; i < 7; i++) begin
         if (v[i].clr) pulse_clear();
         set_ref(v[i].ra, v[i].rb);
         do_sweep(v[i].e, v[i].mu);
         chk($sformatf("v%0d_ndone", i), ndone, 1);
         chk($sformatf("v%0d_done_edge", i), dcyc, TAPS + 1);
         chk($sformatf("v%0d_busy_last", i), bsnap[TAPS], 1);
         chk($sformatf("v%0d_busy_after", i), bsnap[TAPS+1], 0);
         chk($sformatf("v%0d_sat", i), b.sat, 0);
         for (int k = 0; k < TAPS; k++)
            chk($sformatf("v%0d_w%0d", i, k), wof(b.weight_flat, k), v[i].xa + v[i].xb * k);
         if (i == 0) begin
            chk("lat_w0_e1", wof(snap[1], 0), 0);
            chk("lat_w0_e2", wof(snap[2], 0), 3);
            chk("lat_w31_e32", wof(snap[TAPS], TAPS - 1), 0);
            chk("lat_w31_e33", wof(snap[TAPS+1], TAPS - 1), 96);
         end
      end

      pulse_clear();
      set_ref(1, 1);
      b.e = 14'sd3; b.mu_shift = '0; b.start = 1'b1;
      @(negedge clk);
      b.start = 1'b0;
      repeat (9) @(negedge clk);
      chk("clr_pre_w0", wof(b.weight_flat, 0), 3);
      b.start = 1'b1; b.clear = 1'b1;
      @(negedge clk);
      b.start = 1'b0; b.clear = 1'b0;
      chk("clr_w_zero", b.weight_flat === '0, 1);
      chk("clr_busy", b.busy, 0);
      chk("clr_sat", b.sat, 0);
      n = 0; bseen = 0;
      for (int c = 0; c < TAPS + 8; c++) begin
         @(negedge clk);
         if (b.done === 1'b1) n++;
         if (b.busy !== 1'b0) bseen++;
      end
      chk("clr_no_done", n, 0);
      chk("clr_start_dropped", bseen, 0);

      pulse_clear();
      set_ref(1, 1);
      n = 0; d1 = -1; d2 = -1;
      for (int c = 0; c <= TAPS + 40; c++) begin
         b.start    = (c == 0 || c == 5 || c == 20 || c == TAPS + 2);
         b.e        = (c == 0 || c == TAPS + 2) ? 14'sd3 : 14'sd7;
         b.mu_shift = '0;
         @(negedge clk);
         if (b.done === 1'b1) begin
            n++;
            if (d1 < 0) d1 = c;
            else d2 = c;
         end
      end
      b.start = 1'b0;
      chk("b2b_ndone", n, 2);
      chk("b2b_done1", d1, TAPS + 1);
      chk("b2b_done2", d2, 2 * TAPS + 3);
      for (int k = 0; k < TAPS; k++)
         chk($sformatf("b2b_w%0d", k), wof(b.weight_flat, k), 6 * (k + 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
